// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: state encoding,
// display scroll codes and the dwell-timer width helper.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_PAID,
    ST_CHANGE,
    ST_DISPENSE,
    ST_SOLDOUT,
    ST_REFUND
  } state_e;

  localparam logic [2:0] SCROLL_BLANK   = 3'd0;
  localparam logic [2:0] SCROLL_ITEM    = 3'd1;
  localparam logic [2:0] SCROLL_SOLDOUT = 3'd3;
  localparam logic [2:0] SCROLL_ENJOY   = 3'd4;
  localparam logic [2:0] SCROLL_REFUND  = 3'd5;

  // One extra bit so the counter can saturate at a limit equal to LONG_CYC.
  function automatic int unsigned tmr_w(input int unsigned long_cyc);
    return $clog2(long_cyc) + 1;
  endfunction

endpackage

// File: rtl/vend_dwell_timer.sv
// Dwell counter: cleared on state entry, counts up and saturates at limit;
// expire pulses for one cycle when the count reaches limit-1.
module vend_dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expire,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q < limit) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count  = count_q;
  assign expire = (count_q == (limit - W'(1)));

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine transaction sequencer with display decode.
// Optional refund path enabled by defining VEND_CANCEL_EN.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 5,
  parameter int unsigned PRICE_W   = 8,
  parameter int unsigned MONEY_W   = 12,
  parameter int unsigned SHORT_CYC = 50_000_000,
  parameter int unsigned LONG_CYC  = 250_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_ITEMS-1:0]         select,
  input  logic                         buy,
  input  logic                         cancel,
  input  logic [NUM_ITEMS*PRICE_W-1:0] price,
  input  logic [MONEY_W-1:0]           money_in,
  input  logic [NUM_ITEMS-1:0]         stock_empty,
  output logic [2:0]                   scroll_mode,
  output logic                         show_money,
  output logic [MONEY_W-1:0]           amount_display,
  output logic [NUM_ITEMS-1:0]         dispense,
  output logic                         change_valid,
  output logic [MONEY_W-1:0]           change_amt,
  output logic                         busy
);

  localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int unsigned TW = tmr_w(LONG_CYC);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, sel_idx;
  logic [PRICE_W-1:0]   price_q, sel_price;
  logic [MONEY_W-1:0]   price_ext, change_amt_q;
  logic [NUM_ITEMS-1:0] dispense_q;
  logic                 change_valid_q, busy_q;
  logic                 buy_q, armed_q, buy_edge, cancel_req;
  logic                 tmr_clear, tmr_expire;
  logic [TW-1:0]        tmr_limit, tmr_count;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_req    = 1'b0;
`endif

  // armed_q masks the first cycle after reset so a held-high buy is not an edge.
  assign buy_edge  = buy & ~buy_q & armed_q;
  assign price_ext = MONEY_W'(price_q);

  always_comb begin
    sel_idx   = '0;
    sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (select[i]) begin
        sel_idx   = IW'(i);
        sel_price = price[i*PRICE_W +: PRICE_W];
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_SELECTED, ST_CHANGE, ST_REFUND: tmr_limit = TW'(SHORT_CYC);
      default:                           tmr_limit = TW'(LONG_CYC);
    endcase
  end

  assign tmr_clear = (state_d != state_q);

  vend_dwell_timer #(.W(TW)) u_timer (
    .clk    (clock),
    .rst    (reset),
    .clear  (tmr_clear),
    .limit  (tmr_limit),
    .expire (tmr_expire),
    .count  (tmr_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (buy_edge && $onehot(select)) state_d = ST_SELECTED;
      end
      ST_SELECTED: begin
        if (select == '0)                state_d = ST_IDLE;
        else if (cancel_req)             state_d = ST_REFUND;
        else if (money_in >= price_ext)  state_d = ST_PAID;
      end
      ST_PAID: begin
        if (select == '0)                state_d = ST_IDLE;
        else if (cancel_req)             state_d = ST_REFUND;
        else if (tmr_expire) begin
          if (stock_empty[idx_q])        state_d = ST_SOLDOUT;
          else if (money_in == price_ext) state_d = ST_DISPENSE;
          else if (money_in > price_ext) state_d = ST_CHANGE;
          else                           state_d = ST_SELECTED;
        end
      end
      ST_CHANGE: begin
        if (tmr_expire) state_d = ST_DISPENSE;
      end
      ST_DISPENSE, ST_SOLDOUT, ST_REFUND: begin
        if (tmr_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      price_q        <= '0;
      change_amt_q   <= '0;
      dispense_q     <= '0;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      buy_q          <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      buy_q          <= buy;
      armed_q        <= 1'b1;
      busy_q         <= (state_d != ST_IDLE);
      dispense_q     <= '0;
      change_valid_q <= 1'b0;
      if (state_q == ST_IDLE && state_d == ST_SELECTED) begin
        idx_q   <= sel_idx;
        price_q <= sel_price;
      end
      if (state_d == ST_DISPENSE && state_q != ST_DISPENSE) begin
        dispense_q[idx_q] <= 1'b1;
      end
      if (state_d == ST_CHANGE && state_q != ST_CHANGE) begin
        change_amt_q   <= money_in - price_ext;
        change_valid_q <= 1'b1;
      end else if (state_d == ST_REFUND && state_q != ST_REFUND) begin
        change_amt_q   <= money_in;
        change_valid_q <= 1'b1;
      end else if (state_q == ST_DISPENSE && state_d != ST_DISPENSE) begin
        change_amt_q <= '0;
      end
    end
  end

  always_comb begin
    scroll_mode    = SCROLL_BLANK;
    show_money     = 1'b0;
    amount_display = '0;
    case (state_q)
      ST_IDLE:     scroll_mode = (select == '0) ? SCROLL_BLANK : SCROLL_ITEM;
      ST_SELECTED: begin
        if (tmr_count < TW'(SHORT_CYC)) begin
          scroll_mode = SCROLL_ITEM;
        end else begin
          show_money     = 1'b1;
          amount_display = money_in;
        end
      end
      ST_PAID: begin
        show_money     = 1'b1;
        amount_display = money_in;
      end
      ST_CHANGE: begin
        show_money     = 1'b1;
        amount_display = change_amt_q;
      end
      ST_SOLDOUT:  scroll_mode = SCROLL_SOLDOUT;
      ST_DISPENSE: scroll_mode = SCROLL_ENJOY;
      ST_REFUND:   scroll_mode = SCROLL_REFUND;
      default:     scroll_mode = SCROLL_BLANK;
    endcase
  end

  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with short dwell values (SHORT=4, LONG=10).
module tb_vend_sequencer;

  logic        clock = 1'b0;
  logic        reset, buy, cancel;
  logic [4:0]  select, stock_empty;
  logic [39:0] price;
  logic [11:0] money_in;
  logic [2:0]  scroll_mode;
  logic        show_money, change_valid, busy;
  logic [11:0] amount_display, change_amt;
  logic [4:0]  dispense;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vend_sequencer #(
    .NUM_ITEMS(5), .PRICE_W(8), .MONEY_W(12), .SHORT_CYC(4), .LONG_CYC(10)
  ) dut (
    .clock(clock), .reset(reset), .select(select), .buy(buy), .cancel(cancel),
    .price(price), .money_in(money_in), .stock_empty(stock_empty),
    .scroll_mode(scroll_mode), .show_money(show_money),
    .amount_display(amount_display), .dispense(dispense),
    .change_valid(change_valid), .change_amt(change_amt), .busy(busy)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_paid(input logic [11:0] money);
    money_in = 12'd0;
    buy = 1'b1;
    cyc(1);
    buy = 1'b0;
    money_in = money;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; buy = 1'b0; cancel = 1'b0;
    select = 5'b0; stock_empty = 5'b0; money_in = 12'd0;
    price = {8'd40, 8'd30, 8'd50, 8'd20, 8'd10};
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_scroll", scroll_mode, 0);
    chk("rst_show", show_money, 0);
    chk("rst_disp", dispense, 0);
    chk("rst_cv", change_valid, 0);
    chk("rst_camt", change_amt, 0);
    reset = 1'b0;
    cyc(2);

    // exact payment
    select = 5'b00100;
    #1 chk("idle_sel_scroll", scroll_mode, 1);
    buy = 1'b1;
    cyc(1);
    buy = 1'b0;
    chk("sel_busy", busy, 1);
    chk("sel_scroll_c1", scroll_mode, 1);
    cyc(3);
    chk("sel_scroll_c4", scroll_mode, 1);
    chk("sel_show_c4", show_money, 0);
    cyc(1);
    money_in = 12'd30;
    #1;
    chk("sel_show_c5", show_money, 1);
    chk("sel_amt_c5", amount_display, 30);
    money_in = 12'd50;
    cyc(1);
    chk("paid_show", show_money, 1);
    chk("paid_amt", amount_display, 50);
    cyc(9);
    chk("paid_c10_disp", dispense, 0);
    chk("paid_c10_show", show_money, 1);
    cyc(1);
    chk("disp_pulse", dispense, 5'b00100);
    chk("disp_scroll", scroll_mode, 4);
    chk("disp_cv", change_valid, 0);
    cyc(1);
    chk("disp_pulse_end", dispense, 0);
    cyc(8);
    chk("disp_c10_scroll", scroll_mode, 4);
    chk("disp_c10_busy", busy, 1);
    cyc(1);
    chk("a_idle_busy", busy, 0);
    chk("a_idle_scroll", scroll_mode, 1);

    // overpayment with change
    start_paid(12'd75);
    cyc(9);
    chk("b_paid_c10", show_money, 1);
    cyc(1);
    chk("chg_valid", change_valid, 1);
    chk("chg_amt", change_amt, 25);
    chk("chg_display", amount_display, 25);
    cyc(1);
    chk("chg_valid_end", change_valid, 0);
    cyc(2);
    chk("chg_c4_display", amount_display, 25);
    cyc(1);
    chk("b_disp_pulse", dispense, 5'b00100);
    chk("b_camt_hold", change_amt, 25);
    cyc(9);
    chk("b_disp_c10", scroll_mode, 4);
    cyc(1);
    chk("b_idle_busy", busy, 0);
    chk("b_camt_clear", change_amt, 0);

    // sold out
    stock_empty = 5'b00100;
    start_paid(12'd50);
    cyc(9);
    cyc(1);
    chk("so_scroll_c1", scroll_mode, 3);
    chk("so_disp", dispense, 0);
    cyc(9);
    chk("so_scroll_c10", scroll_mode, 3);
    chk("so_disp_c10", dispense, 0);
    cyc(1);
    chk("so_idle", busy, 0);
    stock_empty = 5'b0;

    // multi-hot select and abort by clearing select
    select = 5'b00110;
    buy = 1'b1;
    cyc(2);
    chk("multihot_busy", busy, 0);
    buy = 1'b0;
    cyc(1);
    select = 5'b00100;
    start_paid(12'd50);
    cyc(3);
    select = 5'b0;
    cyc(1);
    chk("abort_busy", busy, 0);
    chk("abort_scroll", scroll_mode, 0);
    select = 5'b00100;
    cyc(1);

    // cancel in PAID
    start_paid(12'd50);
    money_in = 12'd40;
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
`ifdef VEND_CANCEL_EN
    chk("ref_cv", change_valid, 1);
    chk("ref_camt", change_amt, 40);
    chk("ref_scroll", scroll_mode, 5);
    cyc(3);
    chk("ref_scroll_c4", scroll_mode, 5);
    cyc(1);
    chk("ref_idle", busy, 0);
`else
    chk("nocan_busy", busy, 1);
    chk("nocan_cv", change_valid, 0);
    chk("nocan_show", show_money, 1);
    chk("nocan_amt", amount_display, 40);
    chk("nocan_scroll", scroll_mode, 0);
    select = 5'b0;
    cyc(1);
    chk("nocan_idle", busy, 0);
    select = 5'b00100;
`endif
    cyc(1);

    // reset during DISPENSE cycle 3, buy held across release
    start_paid(12'd50);
    cyc(10);
    chk("f_disp_pulse", dispense, 5'b00100);
    cyc(2);
    buy = 1'b1;
    reset = 1'b1;
    select = 5'b0;
    #1;
    chk("f_rst_busy", busy, 0);
    chk("f_rst_scroll", scroll_mode, 0);
    chk("f_rst_disp", dispense, 0);
    chk("f_rst_show", show_money, 0);
    chk("f_rst_amt", amount_display, 0);
    cyc(2);
    select = 5'b00100;
    reset = 1'b0;
    cyc(3);
    chk("f_held_busy", busy, 0);
    chk("f_held_scroll", scroll_mode, 1);
    buy = 1'b0;
    cyc(1);
    buy = 1'b1;
    cyc(1);
    chk("f_new_edge", busy, 1);
    buy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
- REQ-001 SHALL have parameter NUM_ITEMS, default 5: number of product slots.
- REQ-002 SHALL have parameter PRICE_W, default 8: width of one price entry.
- REQ-003 SHALL have parameter MONEY_W, default 12, with MONEY_W >= PRICE_W: credit and change width.
- REQ-004 SHALL have parameter SHORT_CYC, default 50_000_000: short dwell, in cycles.
- REQ-005 SHALL have parameter LONG_CYC, default 250_000_000, with LONG_CYC >= SHORT_CYC >= 2: long dwell, in cycles.
- REQ-006 SHALL have port `clock`, input, 1: single clock.
- REQ-007 SHALL have port `reset`, input, 1: asynchronous, active-high reset.
- REQ-008 SHALL have port `select`, input, NUM_ITEMS: product switches, expected one-hot.
- REQ-009 SHALL have port `buy`, input, 1: level input, rising-edge detected internally.
- REQ-010 SHALL have port `cancel`, input, 1: refund request; ignored unless VEND_CANCEL_EN is defined.
- REQ-011 SHALL have port `price`, input, NUM_ITEMS*PRICE_W: packed price table; slot i is at [i*PRICE_W +: PRICE_W].
- REQ-012 SHALL have port `money_in`, input, MONEY_W: inserted credit.
- REQ-013 SHALL have port `stock_empty`, input, NUM_ITEMS: bit i set means slot i is sold out.
- REQ-014 SHALL have port `scroll_mode`, output, 3: message code sent to the display.
- REQ-015 SHALL have port `show_money`, output, 1: numeric display enable.
- REQ-016 SHALL have port `amount_display`, output, MONEY_W: value to display.
- REQ-017 SHALL have port `dispense`, output, NUM_ITEMS: one-cycle, one-hot vend pulse.
- REQ-018 SHALL have port `change_valid`, output, 1: one-cycle pulse marking change_amt as valid.
- REQ-019 SHALL have port `change_amt`, output, MONEY_W: amount to return.
- REQ-020 SHALL have port `busy`, output, 1: high in every state except IDLE.

Function
- REQ-021 SHALL implement the states IDLE, SELECTED, PAID, CHANGE, DISPENSE, SOLDOUT and REFUND; every state entry clears the dwell timer, and a timed state exits when the timer reaches N-1 (dwell of exactly N cycles).
- REQ-022 IDLE SHALL, on a buy rising edge with select exactly one-hot, latch the slot index and its price and go to SELECTED; a buy edge with select zero or multi-hot, or a buy edge in any non-IDLE state, SHALL be ignored.
- REQ-023 SELECTED SHALL go to IDLE when select==0, else go to PAID when money_in >= latched price, otherwise remain (untimed).
- REQ-024 PAID SHALL go to IDLE when select==0, else after LONG_CYC go to SOLDOUT if stock_empty[idx], else DISPENSE if money_in==price, else CHANGE if money_in>price, else back to SELECTED.
- REQ-025 On entry to CHANGE the block SHALL register change_amt = money_in - price (zero-extended to MONEY_W) and pulse change_valid; CHANGE SHALL go to DISPENSE after SHORT_CYC.
- REQ-026 On entry to DISPENSE the block SHALL pulse dispense[idx] for exactly one cycle; DISPENSE SHALL go to IDLE after LONG_CYC.
- REQ-027 SOLDOUT SHALL go to IDLE after LONG_CYC with no dispense pulse.
- REQ-028 When several conditions hold in the same cycle, precedence SHALL be select==0 first, then cancel, then the money or timer condition.
- REQ-029 Display outputs SHALL be decoded combinationally from registered state:
  - IDLE: scroll 0 if select==0, else scroll 1.
  - SELECTED: scroll 1 for the first SHORT_CYC cycles, then show_money=1 with amount=money_in.
  - PAID: show_money=1, amount=money_in.
  - CHANGE: show_money=1, amount=change_amt.
  - SOLDOUT: scroll 3.
  - DISPENSE: scroll 4.
  - REFUND: scroll 5.
  - All unlisted outputs are 0; scroll codes 2, 6 and 7 are reserved.
- REQ-030 change_amt SHALL hold its value until the next change_valid pulse or until the next DISPENSE exits.

Reset
- REQ-031 Reset SHALL force IDLE and clear the timer, latched index, latched price, change_amt, the buy-edge register, dispense, change_valid and busy.
- REQ-032 Reset asserted mid-transaction SHALL abort the transaction without emitting any pulse, and no buy edge SHALL be detected on the first cycle after release while buy is held high.

Configuration
- REQ-033 With VEND_CANCEL_EN defined, cancel=1 in SELECTED or PAID SHALL enter REFUND, set change_amt=money_in, pulse change_valid, and go to IDLE after SHORT_CYC.
- REQ-034 Without VEND_CANCEL_EN, cancel SHALL be ignored, REFUND SHALL be unreachable and scroll 5 SHALL never be produced.

Structure
- REQ-035 Shared package vend_pkg SHALL hold the state encoding, the scroll code constants (SCROLL_BLANK=0, SCROLL_ITEM=1, SCROLL_SOLDOUT=3, SCROLL_ENJOY=4, SCROLL_REFUND=5) and a timer-width function based on $clog2(LONG_CYC).
- REQ-036 The dwell counter SHALL be a sub-module, vend_dwell_timer, with inputs clear and limit and a one-cycle output expire.

Verification (SHORT_CYC=4, LONG_CYC=10, NUM_ITEMS=5, slot 2 price 50)
- REQ-037 Select slot 2, buy edge, money_in=50 → PAID for 10 cycles, DISPENSE with dispense=00100 for one cycle, scroll 4 for 10 cycles, then IDLE.
- REQ-038 Same flow with money_in=75 → CHANGE with change_valid pulse, change_amt=25, amount_display=25 for 4 cycles, then DISPENSE.
- REQ-039 Same flow with stock_empty=00100 and money_in=50 → SOLDOUT with scroll 3 for 10 cycles, no dispense pulse, then IDLE.
- REQ-040 select=00110 with a buy edge → stays IDLE; select cleared to 0 in PAID → IDLE on the next cycle.
- REQ-041 With VEND_CANCEL_EN, cancel in PAID with money_in=40 → REFUND, change_amt=40, scroll 5 for 4 cycles; without the macro, the flow is unaffected.
- REQ-042 Reset asserted during DISPENSE cycle 3 → IDLE, all outputs 0, and buy held high across release produces no transition.
